mem_access_stage: RTL and testbench

//  MEM stage of the 16-bit pipelined core; consumes EX/MEM register outputs (*_mem) directly.

---
 rtl/mem_access_stage_pkg.sv | 8 +
 rtl/mem_access_stage_if.sv | 21 ++
 rtl/mem_access_stage_mem_wb.sv | 38 +++
 rtl/mem_access_stage.sv | 119 +++++++++++
 tb/tb_mem_access_stage.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared widths, limits and state encoding for the MEM stage of the 16-bit core.
package mem_access_stage_pkg;
  localparam int DATA_W   = 16;
  localparam int RA_W     = 3;
  localparam int MAX_WAIT = 15;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} mem_state_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
  parameter int DATA_W = mem_access_stage_pkg::DATA_W
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB pipeline register; a bubble kills the enables and holds address/data.
module mem_wb
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = mem_access_stage_pkg::DATA_W,
  parameter int RA_W   = mem_access_stage_pkg::RA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bubble,
  input  logic              reg_write_in,
  input  logic [RA_W-1:0]   reg_addr_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              branch_in,
  output logic              reg_write_wb,
  output logic [RA_W-1:0]   reg_addr_wb,
  output logic [DATA_W-1:0] wb_data_wb,
  output logic              branch_wb
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      reg_write_wb <= 1'b0;
      reg_addr_wb  <= '0;
      wb_data_wb   <= '0;
      branch_wb    <= 1'b0;
    end else if (bubble) begin
      reg_write_wb <= 1'b0;
      branch_wb    <= 1'b0;
    end else begin
      reg_write_wb <= reg_write_in;
      reg_addr_wb  <= reg_addr_in;
      wb_data_wb   <= wb_data_in;
      branch_wb    <= branch_in;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack handshake with bounded wait, upstream stall,
// write-back select and MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W   = mem_access_stage_pkg::DATA_W,
  parameter int RA_W     = mem_access_stage_pkg::RA_W,
  parameter int MAX_WAIT = mem_access_stage_pkg::MAX_WAIT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      op_branch_mem,
  input  logic                      op_mem_write_mem,
  input  logic                      op_mem_read_mem,
  input  logic                      op_reg_write_mem,
  input  logic                      op_reg_write_address_mem,
  input  logic                      op_mdr_mem,
  input  logic                      op_res_mem,
  input  logic [RA_W-1:0]           rs_mem,
  input  logic [RA_W-1:0]           rd_mem,
  input  logic [DATA_W-1:0]         ar_mem,
  input  logic [DATA_W-1:0]         data_register_mem,
  mem_access_stage_if.master        dmem,
  output logic                      stall_mem,
  output logic                      reg_write_wb,
  output logic [RA_W-1:0]           reg_addr_wb,
  output logic [DATA_W-1:0]         wb_data_wb,
  output logic                      branch_wb,
  output logic                      timeout_err
);

  localparam int             CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_WAIT);

  mem_state_t        state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              mem_op, at_max, issue, done, abort, rd_ok;
  logic [DATA_W-1:0] wb_sel;

  assign mem_op = op_mem_read_mem | op_mem_write_mem;
  assign at_max = (cnt == CNT_MAX);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
          issue     = 1'b1;
        end
      end
      REQ: begin
        if (dmem.dmem_ack) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else if (at_max) begin
          state_nxt = IDLE;
          done      = 1'b1;
          abort     = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Completion releases the stall in the same cycle so EX/MEM advances at this edge.
  assign stall_mem = mem_op & ~done;

  // Load data only counts for a genuine load acked while a request is outstanding.
  assign rd_ok  = (state == REQ) & dmem.dmem_ack & op_mem_read_mem & ~op_mem_write_mem;
  assign wb_sel = op_mdr_mem ? (rd_ok ? dmem.dmem_rdata : '0)
                : op_res_mem ? ar_mem : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      dmem.dmem_req    <= 1'b0;
      dmem.dmem_we     <= 1'b0;
      dmem.dmem_addr   <= '0;
      dmem.dmem_wdata  <= '0;
      timeout_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (issue) begin
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= op_mem_write_mem;
        dmem.dmem_addr  <= ar_mem;
        dmem.dmem_wdata <= data_register_mem;
      end else if (done) begin
        dmem.dmem_req <= 1'b0;
      end
      if (abort) timeout_err <= 1'b1;
    end
  end

  mem_wb #(.DATA_W(DATA_W), .RA_W(RA_W)) u_mem_wb (
    .clock        (clock),
    .reset        (reset),
    .bubble       (stall_mem),
    .reg_write_in (op_reg_write_mem),
    .reg_addr_in  (op_reg_write_address_mem ? rs_mem : rd_mem),
    .wb_data_in   (wb_sel),
    .branch_in    (op_branch_mem),
    .reg_write_wb (reg_write_wb),
    .reg_addr_wb  (reg_addr_wb),
    .wb_data_wb   (wb_data_wb),
    .branch_wb    (branch_wb)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: drives EX/MEM as a stalling source and
// scoreboards each instruction's MEM/WB result against a small model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int MW = MAX_WAIT;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              op_branch_mem, op_mem_write_mem, op_mem_read_mem, op_reg_write_mem;
  logic              op_reg_write_address_mem, op_mdr_mem, op_res_mem;
  logic [RA_W-1:0]   rs_mem, rd_mem;
  logic [DATA_W-1:0] ar_mem, data_register_mem;
  logic              stall_mem, reg_write_wb, branch_wb, timeout_err;
  logic [RA_W-1:0]   reg_addr_wb;
  logic [DATA_W-1:0] wb_data_wb;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic              rw;
    logic [RA_W-1:0]   addr;
    logic [DATA_W-1:0] data;
    logic              br;
  } exp_t;

  typedef struct {
    logic              br, we, re, rw, rwa, mdr, res;
    logic [RA_W-1:0]   rs, rd;
    logic [DATA_W-1:0] ar, dat;
  } instr_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  mem_access_stage_if dmem_bus ();

  mem_access_stage dut (
    .clock                    (clock),
    .reset                    (reset),
    .op_branch_mem            (op_branch_mem),
    .op_mem_write_mem         (op_mem_write_mem),
    .op_mem_read_mem          (op_mem_read_mem),
    .op_reg_write_mem         (op_reg_write_mem),
    .op_reg_write_address_mem (op_reg_write_address_mem),
    .op_mdr_mem               (op_mdr_mem),
    .op_res_mem               (op_res_mem),
    .rs_mem                   (rs_mem),
    .rd_mem                   (rd_mem),
    .ar_mem                   (ar_mem),
    .data_register_mem        (data_register_mem),
    .dmem                     (dmem_bus.master),
    .stall_mem                (stall_mem),
    .reg_write_wb             (reg_write_wb),
    .reg_addr_wb              (reg_addr_wb),
    .wb_data_wb               (wb_data_wb),
    .branch_wb                (branch_wb),
    .timeout_err              (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input instr_t i);
    op_branch_mem            = i.br;
    op_mem_write_mem         = i.we;
    op_mem_read_mem          = i.re;
    op_reg_write_mem         = i.rw;
    op_reg_write_address_mem = i.rwa;
    op_mdr_mem               = i.mdr;
    op_res_mem               = i.res;
    rs_mem                   = i.rs;
    rd_mem                   = i.rd;
    ar_mem                   = i.ar;
    data_register_mem        = i.dat;
  endtask

  // ack_after: REQ-cycle index carrying ack (0 = first REQ cycle), <0 = never.
  task automatic run(input string nm, input instr_t i, input int ack_after,
                     input logic [DATA_W-1:0] rdata);
    bit   is_mem, acked, done, exp_stall;
    int   exp_occ;
    exp_t e, got;
    is_mem  = i.re | i.we;
    acked   = is_mem && ack_after >= 0 && ack_after <= MW;
    e.rw    = i.rw;
    e.addr  = i.rwa ? i.rs : i.rd;
    e.data  = i.mdr ? ((i.re && !i.we && acked) ? rdata : '0) : (i.res ? i.ar : '0);
    e.br    = i.br;
    sb.push_back(e);
    exp_occ = !is_mem ? 1 : (acked ? ack_after + 2 : MW + 2);
    done    = 1'b0;
    @(negedge clock);
    drive(i);
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) @(negedge clock);
      dmem_bus.dmem_ack   = is_mem && c >= 1 && (c - 1) == ack_after;
      dmem_bus.dmem_rdata = dmem_bus.dmem_ack ? rdata : 16'hDEAD;
      #1;
      exp_stall = is_mem && !(c >= 1 && ((c - 1) == ack_after || (c - 1) == MW));
      chk({nm, ".stall"}, 32'(stall_mem), 32'(exp_stall));
      if (is_mem && c >= 1) begin
        chk({nm, ".req"},   32'(dmem_bus.dmem_req),   32'(1));
        chk({nm, ".we"},    32'(dmem_bus.dmem_we),    32'(i.we));
        chk({nm, ".addr"},  32'(dmem_bus.dmem_addr),  32'(i.ar));
        chk({nm, ".wdata"}, 32'(dmem_bus.dmem_wdata), 32'(i.dat));
      end else begin
        chk({nm, ".req_idle"}, 32'(dmem_bus.dmem_req), 32'(0));
      end
      @(posedge clock);
      #1;
      if (exp_stall) begin
        chk({nm, ".bubble_rw"}, 32'(reg_write_wb), 32'(0));
        chk({nm, ".bubble_br"}, 32'(branch_wb),    32'(0));
      end else begin
        done = 1'b1;
        chk({nm, ".occupancy"}, 32'(c + 1), 32'(exp_occ));
        chk({nm, ".req_drop"},  32'(dmem_bus.dmem_req), 32'(0));
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $error("FAIL %s.sb: observed=result expected=empty scoreboard", nm);
        end else begin
          got = sb.pop_front();
          chk({nm, ".reg_write"}, 32'(reg_write_wb), 32'(got.rw));
          chk({nm, ".reg_addr"},  32'(reg_addr_wb),  32'(got.addr));
          chk({nm, ".wb_data"},   32'(wb_data_wb),   32'(got.data));
          chk({nm, ".branch"},    32'(branch_wb),    32'(got.br));
        end
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $error("FAIL %s.bound: observed=no completion expected=completion", nm);
    end
  endtask

  function automatic instr_t mk(input logic br, we, re, rw, rwa, mdr, res,
                                input logic [RA_W-1:0] rs, rd,
                                input logic [DATA_W-1:0] ar, dat);
    instr_t t;
    t.br = br; t.we = we; t.re = re; t.rw = rw; t.rwa = rwa; t.mdr = mdr; t.res = res;
    t.rs = rs; t.rd = rd; t.ar = ar; t.dat = dat;
    return t;
  endfunction

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0));
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.req",       32'(dmem_bus.dmem_req), 32'(0));
    chk("rst.we",        32'(dmem_bus.dmem_we),  32'(0));
    chk("rst.reg_write", 32'(reg_write_wb),      32'(0));
    chk("rst.wb_data",   32'(wb_data_wb),        32'(0));
    chk("rst.branch",    32'(branch_wb),         32'(0));
    chk("rst.timeout",   32'(timeout_err),       32'(0));
    chk("rst.stall",     32'(stall_mem),         32'(0));
    @(negedge clock);
    reset = 1'b1;

    // br we re rw rwa mdr res  rs rd  ar dat
    run("alu",   mk(0, 0, 0, 1, 0, 0, 1, 3'd0, 3'd3, 16'h1234, 16'h0), -1, 16'h0);
    run("load",  mk(0, 0, 1, 1, 0, 1, 0, 3'd0, 3'd5, 16'h0040, 16'h0),  2, 16'hBEEF);
    run("store", mk(0, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0010, 16'h00AA), 0, 16'h0);
    chk("store.timeout", 32'(timeout_err), 32'(0));
    run("mdr_nomem", mk(0, 0, 0, 1, 0, 1, 0, 3'd0, 3'd1, 16'h7777, 16'h0), -1, 16'h0);
    run("rdwr",  mk(0, 1, 1, 1, 0, 1, 0, 3'd0, 3'd2, 16'h0020, 16'h0055), 1, 16'hCAFE);

    run("ld_to", mk(0, 0, 1, 1, 0, 1, 0, 3'd0, 3'd6, 16'h0044, 16'h0), -1, 16'h0);
    chk("ld_to.timeout", 32'(timeout_err), 32'(1));
    run("alu_rs", mk(0, 0, 0, 1, 1, 0, 1, 3'd7, 3'd1, 16'h5555, 16'h0), -1, 16'h0);
    chk("alu_rs.sticky", 32'(timeout_err), 32'(1));

    // Reset in the middle of an outstanding load.
    @(negedge clock);
    drive(mk(0, 0, 1, 1, 0, 1, 0, 3'd0, 3'd4, 16'h0080, 16'h0));
    dmem_bus.dmem_ack = 1'b0;
    @(posedge clock);
    #1;
    chk("rreq.req", 32'(dmem_bus.dmem_req), 32'(1));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rreq.req_off",   32'(dmem_bus.dmem_req), 32'(0));
    chk("rreq.reg_write", 32'(reg_write_wb),      32'(0));
    chk("rreq.reg_addr",  32'(reg_addr_wb),       32'(0));
    chk("rreq.wb_data",   32'(wb_data_wb),        32'(0));
    chk("rreq.timeout",   32'(timeout_err),       32'(0));
    @(negedge clock);
    reset = 1'b1;
    drive(mk(0, 0, 0, 1, 0, 1, 0, 3'd0, 3'd4, 16'h0, 16'h0));
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 16'hFFFF;
    #1;
    chk("late_ack.stall", 32'(stall_mem), 32'(0));
    @(posedge clock);
    #1;
    chk("late_ack.req",       32'(dmem_bus.dmem_req), 32'(0));
    chk("late_ack.reg_write", 32'(reg_write_wb),      32'(1));
    chk("late_ack.wb_data",   32'(wb_data_wb),        32'(0));
    chk("late_ack.reg_addr",  32'(reg_addr_wb),       32'(4));

    run("b2b_ld", mk(0, 0, 1, 1, 0, 1, 0, 3'd0, 3'd2, 16'h0100, 16'h0),  1, 16'h1357);
    run("b2b_st", mk(1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0102, 16'h2468), 0, 16'h0);
    run("branch", mk(1, 0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 16'h0200, 16'h0), -1, 16'h0);
    chk("end.sb_empty", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
